axi_lite_ram_slave: RTL
=======================

// Module: axi_lite_ram_slave
// PURPOSE
//   AXI4-Lite responder backed by a word-addressed synchronous RAM. It is the slave end of the
//   CPU's AXI-Lite data/instruction port inside top_axi. It accepts AW/W/B writes and AR/R reads
//   independently, applies byte strobes, and returns DECERR for addresses outside its window.
// PARAMETERS
//   ADDR_WIDTH   32            AXI address width
//   DATA_WIDTH   32            data width; only 32 is supported
//   DEPTH_WORDS  4096          RAM size in 32-bit words; must be a power of two
//   BASE_ADDR    32'h0000_0000 byte address of word 0; must be aligned to 4*DEPTH_WORDS
// PORTS
//   ACLK     in  1            clock; all logic on the rising edge
//   ARESETn  in  1            synchronous active-low reset
//   AWADDR   in  ADDR_WIDTH   write address; bits [1:0] are ignored
//   AWPROT   in  3            ignored
//   AWVALID  in  1 / AWREADY out 1   write-address handshake
//   WDATA    in  32 / WSTRB in 4     write data and byte enables
//   WVALID   in  1 / WREADY  out 1   write-data handshake
//   BRESP    out 2 / BVALID out 1 / BREADY in 1   write response
//   ARADDR   in  ADDR_WIDTH   read address; bits [1:0] are ignored
//   ARPROT   in  3            ignored
//   ARVALID  in  1 / ARREADY out 1   read-address handshake
//   RDATA    out 32 / RRESP out 2 / RVALID out 1 / RREADY in 1   read data
// BEHAVIOUR
//   Reset: while ARESETn=0, all READY and VALID outputs are 0, BRESP=RRESP=0, RDATA=0, and the
//     aw_held, w_held and rdy_en flags clear. RAM contents are not reset. rdy_en is set on the
//     first edge with ARESETn=1, so the READY outputs rise 1 cycle after reset is released.
//   Decode: hit = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 4*DEPTH_WORDS).
//     Word index = addr[log2(DEPTH_WORDS)+1:2].
//   Write path (states W_COLLECT, W_RESP):
//     - W_COLLECT: AWREADY = rdy_en & ~aw_held; WREADY = rdy_en & ~w_held.
//       The AW and W handshakes are latched independently into hold registers, in either order
//       or in the same cycle.
//     - On the first edge at which aw_held and w_held are both already 1, the RAM is written and
//       the state moves to W_RESP. Each byte i is written only when WSTRB[i]=1 and hit=1.
//       In the same edge BVALID is set to 1 and BRESP to 2'b00 (hit) or 2'b11 (miss, RAM
//       unchanged). Latency from AW and W both handshaking on edge N: the RAM is written and
//       BVALID=1 at edge N+1.
//     - W_RESP: AWREADY=WREADY=0. BVALID and BRESP hold until BREADY=1. The edge with
//       BVALID&BREADY clears BVALID, clears both hold flags, and returns to W_COLLECT.
//       Minimum write throughput is one write every 3 cycles.
//   Read path (states R_IDLE, R_RESP):
//     - R_IDLE: ARREADY = rdy_en. On an AR handshake at edge N, the RAM word is read
//       synchronously. RDATA, RRESP and RVALID=1 are valid after edge N, so the latency is 1
//       cycle. On a miss, RDATA=0 and RRESP=2'b11; otherwise RRESP=2'b00.
//     - R_RESP: ARREADY=0. RDATA and RRESP are stable until RVALID&RREADY, which clears RVALID
//       and returns to R_IDLE.
//   Simultaneous events:
//     - Read and write paths are fully independent.
//     - A read sampled on the same edge as a write to the same word returns the old data
//       (read-before-write).
//     - WSTRB=0 with hit=1 completes with OKAY and leaves the RAM unchanged.
//   Reset mid-operation: held AW/W and any pending B or R responses are dropped. A RAM write
//     that has not yet occurred is never performed.
// TESTING
//   1. Write 0xDEADBEEF to 0x10, WSTRB=0xF, AW and W in the same cycle -> BVALID 1 cycle later,
//      BRESP=00. Then read 0x10 -> RVALID 1 cycle after AR, RDATA=0xDEADBEEF, RRESP=00.
//   2. W (0x11223344, WSTRB=0101) presented 2 cycles before AW to 0x10 -> BRESP=00.
//      Read 0x10 -> 0xDE22BE44.
//   3. BREADY held 0 for 5 cycles after BVALID -> BVALID/BRESP stable and AWREADY=WREADY=0
//      throughout. The next write is accepted only on the cycle after the B handshake.
//   4. Write and read at BASE_ADDR+4*DEPTH_WORDS -> BRESP=11, then RRESP=11 and RDATA=0.
//      Read of word DEPTH_WORDS-1 is unchanged.
//   5. RREADY held 0 for 3 cycles -> RDATA/RRESP stable, ARREADY=0; ARREADY=1 the cycle after
//      the R handshake.
//   6. ARESETn pulsed low for 2 cycles while BVALID=1 and RVALID=1 -> all VALID/READY outputs
//      are 0 during reset. READY outputs are 1 exactly 1 cycle after release. No spurious
//      B or R response appears.

Source files
------------

// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite slave backed by a word-addressed synchronous RAM.
// Write (AW/W/B) and read (AR/R) paths run independently.
module axi_lite_ram_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [2:0]            AWPROT,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [31:0]           WDATA,
  input  logic [3:0]            WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [2:0]            ARPROT,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [31:0]           RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] LO =
    {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] HI =
    LO + (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

  typedef enum logic {W_COLLECT, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  function automatic logic hit(
    input logic [ADDR_WIDTH-1:0] a
  );
    return ({1'b0, a} >= LO) && ({1'b0, a} < HI);
  endfunction

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                  rdy_en_q, rdy_en_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [31:0]           rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic aw_fire, w_fire, ar_fire;
  logic do_write, aw_hit, ar_hit;
  logic unused_ok;

  assign unused_ok = ^{AWPROT, ARPROT};

  assign AWREADY = rdy_en_q & ~aw_held_q
                 & (w_state_q == W_COLLECT);
  assign WREADY  = rdy_en_q & ~w_held_q
                 & (w_state_q == W_COLLECT);
  assign ARREADY = rdy_en_q & (r_state_q == R_IDLE);
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  assign aw_fire  = AWVALID & AWREADY;
  assign w_fire   = WVALID & WREADY;
  assign ar_fire  = ARVALID & ARREADY;
  assign aw_hit   = hit(awaddr_q);
  assign ar_hit   = hit(ARADDR);
  assign do_write = (w_state_q == W_COLLECT)
                  & aw_held_q & w_held_q;

  always_comb begin
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    rdy_en_d  = 1'b1;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    if (aw_fire) begin
      aw_held_d = 1'b1;
      awaddr_d  = AWADDR;
    end
    if (w_fire) begin
      w_held_d = 1'b1;
      wdata_d  = WDATA;
      wstrb_d  = WSTRB;
    end
    unique case (w_state_q)
      W_COLLECT: begin
        if (do_write) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = aw_hit ? 2'b00 : 2'b11;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          w_state_d = W_COLLECT;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: w_state_d = W_COLLECT;
    endcase
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
          rresp_d   = ar_hit ? 2'b00 : 2'b11;
        end
      end
      R_RESP: begin
        if (RREADY) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_state_q <= W_COLLECT;
      r_state_q <= R_IDLE;
      rdy_en_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      rdy_en_q  <= rdy_en_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
    end
  end

  // RAM has no reset; NBA ordering gives read-before-write on the same word
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rdata_q <= '0;
    end else begin
      if (do_write && aw_hit) begin
        for (int i = 0; i < 4; i++) begin
          if (wstrb_q[i]) begin
            mem[awaddr_q[IDX_W+1:2]][8*i +: 8]
              <= wdata_q[8*i +: 8];
          end
        end
      end
      if (ar_fire) begin
        rdata_q <= ar_hit ? mem[ARADDR[IDX_W+1:2]]
                          : 32'h0;
      end
    end
  end

endmodule
